// File: rtl/serial_right_shifter_pkg.sv
// serial_right_shifter_pkg: shared shifter defaults and state encoding
package serial_right_shifter_pkg;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned SHAMT_W_DEF = 5;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
endpackage

// File: rtl/serial_right_shifter_shift_step.sv
// serial_right_shifter_shift_step: one-bit right shift with caller-supplied fill bit
module serial_right_shifter_shift_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              fill_i,
  output logic [DATA_W-1:0] data_o
);
  assign data_o = {fill_i, data_i[DATA_W-1:1]};
endmodule

// File: rtl/serial_right_shifter.sv
// serial_right_shifter: multi-cycle logical/arithmetic right shift, one bit per cycle
module serial_right_shifter
  import serial_right_shifter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               arith_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [DATA_W-1:0]  data_o
);
  state_t state;
  logic [DATA_W-1:0] work, work_nxt;
  logic [SHAMT_W-1:0] cnt;
  logic fill;
  serial_right_shifter_shift_step #(.DATA_W(DATA_W)) u_step (
    .data_i(work),
    .fill_i(fill),
    .data_o(work_nxt)
  );
  // a start seen while the done pulse is still out is held off one cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= S_IDLE;
      work   <= '0;
      cnt    <= '0;
      fill   <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      data_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: if (start_i && !done_o) begin
          work   <= data_i;
          cnt    <= shamt_i;
          fill   <= arith_i & data_i[DATA_W-1];
          busy_o <= 1'b1;
          state  <= (shamt_i != '0) ? S_SHIFT : S_DONE;
        end
        S_SHIFT: begin
          work <= work_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) state <= S_DONE;
        end
        S_DONE: begin
          data_o <= work;
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_right_shifter.sv
// tb_serial_right_shifter: randomized check of the serial shifter against a >>/>>> reference
module tb_serial_right_shifter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [31:0] data = '0;
  logic [4:0] shamt = '0;
  logic arith = 1'b0;
  logic busy, done;
  logic [31:0] result;
  logic [31:0] prev_result = '0;
  int checks = 0;
  int errors = 0;

  serial_right_shifter dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .start_i(start),
    .data_i(data),
    .shamt_i(shamt),
    .arith_i(arith),
    .busy_o(busy),
    .done_o(done),
    .data_o(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // noise: 0 quiet, 1 random start/data while busy, 2 start pulses at cycle 2 and in DONE
  task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic a, input int noise);
    logic [31:0] exp;
    int m;
    bit seen;
    if (a) exp = $signed(d) >>> s;
    else exp = d >> s;
    @(negedge clk);
    start = 1'b1; data = d; shamt = s; arith = a;
    @(negedge clk);
    start = 1'b0; data = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
    m = 0;
    seen = 0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    while (!seen && m <= 40) begin
      if (done) seen = 1;
      else begin
        check("hold_result", result, prev_result);
        start = (noise == 1) ? 1'($urandom_range(0, 1)) : (noise == 2) ? (m == 2 || m == int'(s)) : 1'b0;
        data = $urandom;
        shamt = 5'($urandom);
        arith = 1'($urandom);
        @(negedge clk);
        m++;
      end
    end
    start = 1'b0;
    check("done_seen", {31'b0, seen}, 32'd1);
    check("latency", 32'(m), 32'(s) + 32'd1);
    check("result", result, exp);
    check("busy_at_done", {31'b0, busy}, 32'd0);
    prev_result = exp;
    @(negedge clk);
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("result_held", result, exp);
  endtask

  initial begin
    bit late_done;
    #2;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_data", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'hF000_0000, 5'd4, 1'b0, 0);
    run_op(32'h8000_0000, 5'd31, 1'b1, 0);
    run_op(32'h8000_0000, 5'd31, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 5'd31, 1'b1, 0);
    run_op(32'h1234_5678, 5'd0, 1'b1, 0);
    run_op(32'hA5A5_0F0F, 5'd8, 1'b1, 2);
    // abort a shamt=10 operation after its third shift cycle
    @(negedge clk);
    start = 1'b1; data = 32'hDEAD_BEEF; shamt = 5'd10; arith = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_data", result, 32'd0);
    prev_result = '0;
    @(negedge clk);
    rst_n = 1'b1;
    late_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) late_done = 1;
    end
    check("no_done_after_abort", {31'b0, late_done}, 32'd0);
    run_op(32'hC0DE_1234, 5'd5, 1'b1, 0);
    for (int i = 0; i < 1000; i++) begin
      logic [4:0] s;
      s = (i % 50 == 0) ? 5'd31 : (i % 50 == 1) ? 5'd0 : 5'($urandom);
      run_op($urandom, s, 1'($urandom), (i % 3 == 0) ? 1 : 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
